rf_wb_scheduler: RTL
====================

Name: rf_wb_scheduler

Overview:
- Shares the single RegFile write port between the core's same-cycle writeback and one long-latency unit (LLU, e.g. load/mul-div).
- Keeps a 32-entry busy scoreboard of registers owned by in-flight LLU ops.
- Stalls the core on RAW/WAW hazards against busy registers.
- Sits between the core writeback path, the LLU and the RegFile write port (rsW/dataW/RegWEn).

Parameters:
- STARVE_LIMIT, 4: consecutive cycles an LLU result may wait before the core is forcibly stalled; legal range 1..15.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_we  in  1  core writeback request this cycle
- core_rd  in  5  core destination register
- core_data  in  XLEN  core writeback data
- issue_valid  in  1  core issues an LLU op this cycle
- issue_rd  in  5  destination of the issued LLU op
- rs1  in  5  core source register 1 (decode)
- rs2  in  5  core source register 2 (decode)
- llu_valid  in  1  LLU result available; held until accepted
- llu_rd  in  5  LLU result destination
- llu_data  in  XLEN  LLU result data
- llu_ready  out  1  LLU result accepted this cycle
- hazard_stall  out  1  core must hold PC and suppress its side effects this cycle
- RegWEn  out  1  RegFile write enable
- rsW  out  5  RegFile write address
- dataW  out  XLEN  RegFile write data
- fwd1_hit  out  1  rs1 value is supplied on fwd_data
- fwd2_hit  out  1  rs2 value is supplied on fwd_data
- fwd_data  out  XLEN  forwarded LLU data

Behaviour:
- Reset (async, rst_n=0):
  - busy[31:0]=0, state=NORMAL, wait_cnt=0.
  - While rst_n=0, all outputs are forced to 0.
- x0 handling: x0 is never busy. Writes to x0 from either source are dropped: no RegWEn, but llu_ready still accepts an x0 LLU result.
- hazard_stall is combinational and is 1 when any of the following holds:
  - state==FORCE;
  - rs1 or rs2 is busy and not forwarded;
  - core_we and core_rd are busy (WAW);
  - issue_valid and issue_rd are busy (WAW).
- core_eff = core_we & !hazard_stall & core_rd!=0.
- llu_ready = llu_valid & (state==FORCE | !core_we | hazard_stall). The core has priority; the LLU fills idle or stalled cycles.
- Port mux:
  - If llu_ready and llu_rd!=0, write the LLU data.
  - Else if core_eff, write the core data.
  - Else RegWEn=0.
  - Zero-latency: RegWEn/rsW/dataW are combinational, and the RegFile commits at the next posedge.
- Scoreboard update at posedge:
  - On an LLU accept, clear busy[llu_rd].
  - On issue_valid & !hazard_stall & issue_rd!=0, set busy[issue_rd].
  - If both events target the same rd in one cycle: the issue stalls because busy is still set, so there is no conflict.
- State FSM:
  - NORMAL: wait_cnt counts up while llu_valid & !llu_ready and clears otherwise. At wait_cnt==STARVE_LIMIT-1 with the LLU still blocked, go to FORCE.
  - FORCE (exactly 1 cycle): hazard_stall=1, LLU granted, core write suppressed (the core replays). Return to NORMAL with wait_cnt=0.
- llu_valid while llu_rd is not busy is a protocol error: the result is still written and the busy bit is left at 0.
- Reset asserted mid-operation discards all busy bits; the LLU is reset by the same rst_n.

Optional Feature:
- RF_BYPASS_EN defined: when the LLU is accepted this cycle and llu_rd!=0 matches rs1 (or rs2), the matching fwd1_hit (or fwd2_hit) is 1, fwd_data=llu_data, and that source does not cause a stall.
- RF_BYPASS_EN undefined: fwd1_hit=fwd2_hit=0, fwd_data=0, and the core stalls until the busy bit clears. This costs one extra cycle, because the RegFile provides the value the cycle after commit.
- In both cases the ports exist.

Decomposition:
- Package rf_sched_pkg holds:
  - the enum sched_state_e {NORMAL, FORCE};
  - localparam REG_CNT=32;
  - REG_ADDR_W=5;
  - typedef reg_addr_t.
- Sub-module rf_scoreboard: the busy vector with set/clear ports and two read-lookup ports plus a WAW lookup.
- The FSM, arbitration and forwarding stay in the top level.

Test Plan:
- Reset, then core_we=1, core_rd=5, core_data=0x1234 -> same cycle RegWEn=1, rsW=5, dataW=0x1234, hazard_stall=0. After the posedge the RegFile holds x5=0x1234.
- issue_valid, issue_rd=6. Next cycle rs1=6 -> hazard_stall=1. llu_valid, llu_rd=6, llu_data=0xCAFEBABE, core_we=0 -> llu_ready=1, RegWEn=1, rsW=6. Next cycle hazard_stall=0 (without bypass).
- With RF_BYPASS_EN, repeat the previous case -> in the accept cycle fwd1_hit=1, fwd_data=0xCAFEBABE, hazard_stall=0.
- STARVE_LIMIT=4, llu_valid held with core_we=1 on every cycle -> llu_ready=0 for 4 cycles. The 5th cycle is FORCE: hazard_stall=1, llu_ready=1, core write dropped.
- issue_rd=0 then llu_rd=0 -> busy stays 0, RegWEn=0, llu_ready=1.
- Set busy[7], then drop rst_n mid-wait -> all outputs 0 immediately. After release, rs1=7 gives no stall.

Source files
------------

// File: rtl/rf_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : rf_sched_pkg
// Purpose  : Shared types and constants for the RegFile writeback scheduler.
//            Defines the scheduler state enum, the register count and the
//            register address type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rf_sched_pkg;

    localparam int REG_CNT    = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : rf_scoreboard
// Purpose  : Busy bit per architectural register, marking registers owned by
//            an in-flight long-latency op.
// Ports    : clk, rst_n          - clock, async active-low reset
//            set_en/set_rd       - mark a register busy at the next edge
//            clr_en/clr_rd       - release a register at the next edge
//            rd_addr1/rd_busy1   - source lookup 1
//            rd_addr2/rd_busy2   - source lookup 2
//            waw_addr_a/_busy_a  - destination (WAW) lookup, core writeback
//            waw_addr_b/_busy_b  - destination (WAW) lookup, LLU issue
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_scoreboard
    import rf_sched_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      set_en,
    input  reg_addr_t set_rd,
    input  logic      clr_en,
    input  reg_addr_t clr_rd,
    input  reg_addr_t rd_addr1,
    input  reg_addr_t rd_addr2,
    output logic      rd_busy1,
    output logic      rd_busy2,
    input  reg_addr_t waw_addr_a,
    output logic      waw_busy_a,
    input  reg_addr_t waw_addr_b,
    output logic      waw_busy_b
);

    logic [REG_CNT-1:0] busy_q;
    logic [REG_CNT-1:0] busy_d;

    // Clear before set: a same-register set/clear cannot occur because the
    // issue is stalled while the register is still busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;   // x0 is never owned by anybody
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rd_busy1   = busy_q[rd_addr1];
    assign rd_busy2   = busy_q[rd_addr2];
    assign waw_busy_a = busy_q[waw_addr_a];
    assign waw_busy_b = busy_q[waw_addr_b];

endmodule

`default_nettype wire

// File: rtl/rf_wb_scheduler.sv
//------------------------------------------------------------------------------
// Module   : rf_wb_scheduler
// Purpose  : Arbitrates the single RegFile write port between the core's
//            same-cycle writeback and one long-latency unit (LLU), tracks
//            LLU-owned registers and stalls the core on RAW/WAW hazards.
//            A starvation counter forces a one-cycle LLU grant after
//            STARVE_LIMIT consecutive blocked cycles.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            core_we/core_rd/core_data       - core writeback request
//            issue_valid/issue_rd            - LLU op issue
//            rs1/rs2                         - decode source registers
//            llu_valid/llu_rd/llu_data       - LLU result (held until ready)
//            llu_ready                       - LLU result accepted
//            hazard_stall                    - core must hold this cycle
//            RegWEn/rsW/dataW                - RegFile write port
//            fwd1_hit/fwd2_hit/fwd_data      - LLU-to-decode bypass
// Config   : RF_BYPASS_EN - when defined, a result accepted this cycle is
//            forwarded to matching sources instead of stalling them.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_wb_scheduler
    import rf_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_we,
    input  logic [4:0]      core_rd,
    input  logic [XLEN-1:0] core_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic            llu_valid,
    input  logic [4:0]      llu_rd,
    input  logic [XLEN-1:0] llu_data,
    output logic            llu_ready,
    output logic            hazard_stall,
    output logic            RegWEn,
    output logic [4:0]      rsW,
    output logic [XLEN-1:0] dataW,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd_data
);

    sched_state_e state;
    logic [3:0]   wait_cnt;

    logic rs1_busy, rs2_busy, core_rd_busy, issue_rd_busy;
    logic is_force, core_waw, issue_waw, hazard_base;
    logic accept, fwd1, fwd2, stall, core_eff;
    logic llu_wr;

    rf_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (issue_valid & ~stall & (issue_rd != 5'd0)),
        .set_rd     (issue_rd),
        .clr_en     (accept),
        .clr_rd     (llu_rd),
        .rd_addr1   (rs1),
        .rd_addr2   (rs2),
        .rd_busy1   (rs1_busy),
        .rd_busy2   (rs2_busy),
        .waw_addr_a (core_rd),
        .waw_busy_a (core_rd_busy),
        .waw_addr_b (issue_rd),
        .waw_busy_b (issue_rd_busy)
    );

    assign is_force  = (state == FORCE);
    assign core_waw  = core_we & core_rd_busy;
    assign issue_waw = issue_valid & issue_rd_busy;

    // Stall condition before any forwarding is considered. The LLU grant is
    // derived from this to break the loop grant -> forward -> stall -> grant.
    assign hazard_base = is_force | rs1_busy | rs2_busy | core_waw | issue_waw;
    assign accept      = llu_valid & (is_force | ~core_we | hazard_base);

`ifdef RF_BYPASS_EN
    assign fwd1 = accept & (llu_rd != 5'd0) & (llu_rd == rs1);
    assign fwd2 = accept & (llu_rd != 5'd0) & (llu_rd == rs2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // A core write that loses the port to the LLU must be replayed, so the
    // core stalls whenever it wanted to write while the LLU is accepted.
    assign stall = is_force | (rs1_busy & ~fwd1) | (rs2_busy & ~fwd2)
                 | core_waw | issue_waw | (core_we & accept);

    assign core_eff = core_we & ~stall & (core_rd != 5'd0);
    assign llu_wr   = accept & (llu_rd != 5'd0);

    // Outputs are forced low while reset is asserted.
    always_comb begin
        llu_ready    = rst_n & accept;
        hazard_stall = rst_n & stall;
        fwd1_hit     = rst_n & fwd1;
        fwd2_hit     = rst_n & fwd2;
        fwd_data     = (rst_n & (fwd1 | fwd2)) ? llu_data : '0;
        RegWEn       = 1'b0;
        rsW          = 5'd0;
        dataW        = '0;
        if (rst_n) begin
            if (llu_wr) begin
                RegWEn = 1'b1;
                rsW    = llu_rd;
                dataW  = llu_data;
            end else if (core_eff) begin
                RegWEn = 1'b1;
                rsW    = core_rd;
                dataW  = core_data;
            end
        end
    end

    // Starvation guard: counts consecutive cycles the LLU is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= NORMAL;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                NORMAL: begin
                    if (llu_valid & ~accept) begin
                        if (wait_cnt == 4'(STARVE_LIMIT - 1)) begin
                            state    <= FORCE;
                            wait_cnt <= 4'd0;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end else begin
                        wait_cnt <= 4'd0;
                    end
                end
                default: begin
                    state    <= NORMAL;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
